// File: rtl/fc_operand_packer_pkg.sv
// Shared definitions for the FC operand packer: lane-vector type, FSM states,
// default geometry and a group-count helper.
package fc_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_OPS_PER_CYCLE = 10;

  typedef logic [DEF_OPS_PER_CYCLE-1:0][DEF_DATA_WIDTH-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of packed groups fc will see for one input vector.
  function automatic int group_count(input int total, input int ops);
    return (total + ops - 1) / ops;
  endfunction

endpackage

// File: rtl/fc_operand_packer_if.sv
// Serial-in / packed-out bus between the pooling stage, the packer and fc.
interface fc_operand_packer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int OPS_PER_CYCLE = 10
);
  logic                                      start;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [DATA_WIDTH-1:0]                     in_feature;
  logic [DATA_WIDTH-1:0]                     in_weight;
  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0]  operands;
  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0]  weights;
  logic                                      data_valid;
  logic                                      fc_start;
  logic                                      last_group;
  logic                                      done;

  modport master (
    output start, in_valid, in_feature, in_weight,
    input  in_ready, operands, weights, data_valid, fc_start, last_group, done
  );

  modport slave (
    input  start, in_valid, in_feature, in_weight,
    output in_ready, operands, weights, data_valid, fc_start, last_group, done
  );
endinterface

// File: rtl/fc_operand_packer.sv
// Packs a serial (feature, weight) stream into OPS_PER_CYCLE-wide groups for fc,
// zero-padding the final partial group.
module fc_operand_packer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OPS_PER_CYCLE  = DEF_OPS_PER_CYCLE,
  parameter int FC_TOTAL_COUNT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  fc_operand_packer_if.slave bus
);

  localparam int LW = (OPS_PER_CYCLE > 1) ? $clog2(OPS_PER_CYCLE) : 1;
  localparam int EW = $clog2(FC_TOTAL_COUNT + 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(OPS_PER_CYCLE - 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(FC_TOTAL_COUNT - 1);

  typedef logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0] vec_t;

  state_e          state_q, state_d;
  logic [LW-1:0]   lane_cnt_q;
  logic [EW-1:0]   elem_cnt_q;
  vec_t            fop_q, fwt_q, fop_d, fwt_d;
  vec_t            op_q, wt_q;
  logic            dv_q, last_q, done_q, fcs_q;
  logic            accept, last_elem, close;

  assign accept    = bus.in_valid && (state_q == FILL);
  assign last_elem = (elem_cnt_q == ELEM_LAST);
  assign close     = accept && ((lane_cnt_q == LANE_LAST) || last_elem);

  // Fill buffer as it looks after this edge's element lands, so a closing
  // group includes the element accepted on the closing edge.
  always_comb begin
    fop_d = fop_q;
    fwt_d = fwt_q;
    if (accept) begin
      fop_d[lane_cnt_q] = bus.in_feature;
      fwt_d[lane_cnt_q] = bus.in_weight;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = FILL;
      FILL:    if (accept && last_elem) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_cnt_q <= '0;
      elem_cnt_q <= '0;
      fop_q      <= '0;
      fwt_q      <= '0;
      op_q       <= '0;
      wt_q       <= '0;
      dv_q       <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      fcs_q      <= 1'b0;
    end else begin
      dv_q   <= close;
      last_q <= close && last_elem;
      done_q <= (state_q == DONE);

      if (state_q == IDLE && bus.start) begin
        fcs_q      <= 1'b1;
        lane_cnt_q <= '0;
        elem_cnt_q <= '0;
        fop_q      <= '0;
        fwt_q      <= '0;
      end else if (state_q == DONE) begin
        fcs_q <= 1'b0;
      end

      if (accept) begin
        elem_cnt_q <= elem_cnt_q + EW'(1);
        if (close) begin
          op_q       <= fop_d;
          wt_q       <= fwt_d;
          fop_q      <= '0;
          fwt_q      <= '0;
          lane_cnt_q <= '0;
        end else begin
          fop_q      <= fop_d;
          fwt_q      <= fwt_d;
          lane_cnt_q <= lane_cnt_q + LW'(1);
        end
      end
    end
  end

  assign bus.in_ready   = (state_q == FILL);
  assign bus.operands   = op_q;
  assign bus.weights    = wt_q;
  assign bus.data_valid = dv_q;
  assign bus.last_group = last_q;
  assign bus.done       = done_q;
  assign bus.fc_start   = fcs_q;

endmodule

// File: tb/tb_fc_operand_packer.sv
// Scoreboard bench: stimulus pushes expected groups, negedge monitors pop and compare.
module tb_fc_operand_packer;
  import fc_pkg::*;

  typedef struct {
    lane_vec_t op;
    lane_vec_t wt;
    bit        last;
  } grp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fc_operand_packer_if #(.DATA_WIDTH(8), .OPS_PER_CYCLE(10)) ifa ();
  fc_operand_packer_if #(.DATA_WIDTH(8), .OPS_PER_CYCLE(10)) ifb ();

  fc_operand_packer #(.DATA_WIDTH(8), .OPS_PER_CYCLE(10), .FC_TOTAL_COUNT(1024))
    dut_a (.clock(clock), .reset(reset), .bus(ifa));
  fc_operand_packer #(.DATA_WIDTH(8), .OPS_PER_CYCLE(10), .FC_TOTAL_COUNT(20))
    dut_b (.clock(clock), .reset(reset), .bus(ifb));

  int        n_tests = 0;
  int        n_fail  = 0;
  grp_t      exp_a[$];
  grp_t      exp_b[$];
  lane_vec_t cap_op[512];
  lane_vec_t cap_wt[512];
  bit        cap_last[512];
  int        ga = 0;
  int        gb = 0;
  bit        prev_dv_a = 1'b0;
  bit        prev_dv_b = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon_a
    grp_t g;
    if (ifa.data_valid) begin
      chk("a_dv_not_back_to_back", prev_dv_a, 0);
      chk("a_dv_has_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) begin
        g = exp_a.pop_front();
        chk("a_operands", ifa.operands, g.op);
        chk("a_weights", ifa.weights, g.wt);
        chk("a_last_group", ifa.last_group, g.last);
      end
      cap_op[ga]   <= ifa.operands;
      cap_wt[ga]   <= ifa.weights;
      cap_last[ga] <= ifa.last_group;
      ga <= ga + 1;
    end
    prev_dv_a <= ifa.data_valid;
  end

  always @(negedge clock) begin : mon_b
    grp_t g;
    if (ifb.data_valid) begin
      chk("b_dv_not_back_to_back", prev_dv_b, 0);
      chk("b_dv_has_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) begin
        g = exp_b.pop_front();
        chk("b_operands", ifb.operands, g.op);
        chk("b_weights", ifb.weights, g.wt);
        chk("b_last_group", ifb.last_group, g.last);
      end
      gb <= gb + 1;
    end
    prev_dv_b <= ifb.data_valid;
  end

  // Full 1024-element vector on dut_a; start is re-pulsed mid-FILL and must be ignored.
  task automatic run_a(input int seed, input bit drop);
    lane_vec_t mo, mw;
    int ln, c, base;
    logic [7:0] f, w;
    base = ga;
    chk("a_idle_in_ready", ifa.in_ready, 0);
    ifa.start = 1'b1;
    @(negedge clock);
    ifa.start = 1'b0;
    mo = '0; mw = '0; ln = 0; c = 0;
    for (int i = 0; i < 1024; i++) begin
      if (drop && (c % 3 == 2)) begin
        ifa.in_valid = 1'b0;
        ifa.start    = 1'b0;
        c++;
        @(negedge clock);
      end
      f = 8'((i + seed) % 256);
      w = 8'((i + 3) % 4);
      ifa.in_valid   = 1'b1;
      ifa.in_feature = f;
      ifa.in_weight  = w;
      ifa.start      = (i == 50);
      mo[ln] = f;
      mw[ln] = w;
      if (ln == 9 || i == 1023) begin
        exp_a.push_back('{op: mo, wt: mw, last: (i == 1023)});
        mo = '0; mw = '0; ln = 0;
      end else begin
        ln++;
      end
      c++;
      @(negedge clock);
    end
    ifa.in_valid = 1'b0;
    ifa.start    = 1'b0;
    chk("a_final_dv", ifa.data_valid, 1);
    chk("a_final_last", ifa.last_group, 1);
    chk("a_fc_start_during_final", ifa.fc_start, 1);
    chk("a_done_not_early", ifa.done, 0);
    @(negedge clock);
    chk("a_done_pulse", ifa.done, 1);
    chk("a_fc_start_low_at_done", ifa.fc_start, 0);
    chk("a_in_ready_low_at_done", ifa.in_ready, 0);
    chk("a_dv_low_at_done", ifa.data_valid, 0);
    chk("a_group_count", 80'(ga - base), 103);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int b;
    lane_vec_t mo, mw;
    int ln;
    ifa.start = 0; ifa.in_valid = 0; ifa.in_feature = 0; ifa.in_weight = 0;
    ifb.start = 0; ifb.in_valid = 0; ifb.in_feature = 0; ifb.in_weight = 0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_operands", ifa.operands, 0);
    chk("rst_weights", ifa.weights, 0);
    chk("rst_data_valid", ifa.data_valid, 0);
    chk("rst_fc_start", ifa.fc_start, 0);
    chk("rst_last_group", ifa.last_group, 0);
    chk("rst_done", ifa.done, 0);
    reset = 1'b0;
    @(negedge clock);

    // in_valid while IDLE must be ignored
    ifa.in_valid = 1'b1; ifa.in_feature = 8'hAA; ifa.in_weight = 8'h55;
    repeat (3) begin
      @(negedge clock);
      chk("idle_in_ready", ifa.in_ready, 0);
      chk("idle_no_dv", ifa.data_valid, 0);
      chk("idle_no_fc_start", ifa.fc_start, 0);
    end
    ifa.in_valid = 1'b0;
    @(negedge clock);

    // Run 1: reference stream, hand checks on first/last group
    b = ga;
    run_a(0, 1'b0);
    for (int k = 0; k < 10; k++) chk("g0_operand_lane", 80'(cap_op[b][k]), 80'(k));
    chk("g0_weight_lane0", 80'(cap_wt[b][0]), 3);
    chk("g0_weight_lane1", 80'(cap_wt[b][1]), 0);
    chk("g0_not_last", cap_last[b], 0);
    chk("g101_not_last", cap_last[b+101], 0);
    chk("g102_last", cap_last[b+102], 1);
    for (int k = 0; k < 4; k++) chk("g102_operand_lane", 80'(cap_op[b+102][k]), 80'(252 + k));
    for (int k = 4; k < 10; k++) begin
      chk("g102_pad_operand", 80'(cap_op[b+102][k]), 0);
      chk("g102_pad_weight", 80'(cap_wt[b+102][k]), 0);
    end
    @(negedge clock);
    chk("post_done_low", ifa.done, 0);

    // Run 2: in_valid dropped every third cycle
    run_a(0, 1'b1);
    @(negedge clock);

    // Short vector: 20 elements -> exactly two full groups
    b = gb;
    ifb.start = 1'b1;
    @(negedge clock);
    ifb.start = 1'b0;
    mo = '0; mw = '0; ln = 0;
    for (int i = 0; i < 20; i++) begin
      ifb.in_valid   = 1'b1;
      ifb.in_feature = 8'(i + 1);
      ifb.in_weight  = 8'(2 * i + 1);
      mo[ln] = 8'(i + 1);
      mw[ln] = 8'(2 * i + 1);
      if (ln == 9) begin
        exp_b.push_back('{op: mo, wt: mw, last: (i == 19)});
        mo = '0; mw = '0; ln = 0;
      end else ln++;
      @(negedge clock);
    end
    ifb.in_valid = 1'b0;
    chk("b_final_dv", ifb.data_valid, 1);
    chk("b_final_last", ifb.last_group, 1);
    @(negedge clock);
    chk("b_done_pulse", ifb.done, 1);
    chk("b_fc_start_low", ifb.fc_start, 0);
    chk("b_group_count", 80'(gb - b), 2);
    @(negedge clock);

    // Async reset after 15 elements: group 0 issued, partial group 1 discarded
    ifa.start = 1'b1;
    @(negedge clock);
    ifa.start = 1'b0;
    mo = '0; mw = '0; ln = 0;
    for (int i = 0; i < 15; i++) begin
      ifa.in_valid   = 1'b1;
      ifa.in_feature = 8'(i + 7);
      ifa.in_weight  = 8'((i + 3) % 4);
      mo[ln] = 8'(i + 7);
      mw[ln] = 8'((i + 3) % 4);
      if (ln == 9) begin
        exp_a.push_back('{op: mo, wt: mw, last: 1'b0});
        mo = '0; mw = '0; ln = 0;
      end else ln++;
      @(negedge clock);
    end
    ifa.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_operands", ifa.operands, 0);
    chk("arst_weights", ifa.weights, 0);
    chk("arst_in_ready", ifa.in_ready, 0);
    chk("arst_fc_start", ifa.fc_start, 0);
    chk("arst_dv", ifa.data_valid, 0);
    chk("arst_done", ifa.done, 0);
    chk("arst_sb_drained", 80'(exp_a.size()), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("arst_no_dv_after", ifa.data_valid, 0);
      chk("arst_no_done_after", ifa.done, 0);
    end

    // Fresh stream after reset, then a back-to-back vector
    run_a(100, 1'b0);
    @(negedge clock);
    b = ga;
    run_a(0, 1'b0);
    for (int k = 4; k < 10; k++) begin
      chk("b2b_g0_lane_live", 80'(cap_op[b][k]), 80'(k));
      chk("b2b_last_pad", 80'(cap_op[b+102][k]), 0);
    end

    @(negedge clock);
    chk("end_sb_a_empty", 80'(exp_a.size()), 0);
    chk("end_sb_b_empty", 80'(exp_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
